fifo_in: RTL and testbench



---
 rtl/fifo_in_pkg.sv | 29 ++
 rtl/fifo_in_sync2.sv | 24 ++
 rtl/fifo_in.sv | 124 ++++++++++++
 tb/tb_fifo_in.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_in_pkg.sv
// Shared constants and Gray-code helpers for the fifo_in
// 32-bit-in / 256-bit-out dual-clock FIFO.
package fifo_in_pkg;

    localparam int WR_AW  = 10;
    localparam int WR_DW  = 32;
    localparam int RD_AW  = 7;
    localparam int RD_DW  = 256;
    localparam int AF_NUM = 1020;
    localparam int AE_NUM = 4;
    localparam int PTR_W  = WR_AW + 1;

    function automatic logic [PTR_W-1:0] bin2gray(
        input logic [PTR_W-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_W-1:0] gray2bin(
        input logic [PTR_W-1:0] g
    );
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/fifo_in_sync2.sv
// Two-flop synchronizer for Gray-coded pointers,
// cleared asynchronously by rst.
module fifo_in_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/fifo_in.sv
// Dual-clock FIFO: 1024 x 32 write side packed into 128 x 256 read
// side, oldest write in the low word of each read word.
module fifo_in
    import fifo_in_pkg::*;
#(
    parameter int WR_DEPTH_WIDTH   = WR_AW,
    parameter int WR_DATA_WIDTH    = WR_DW,
    parameter int RD_DEPTH_WIDTH   = RD_AW,
    parameter int RD_DATA_WIDTH    = RD_DW,
    parameter int ALMOST_FULL_NUM  = AF_NUM,
    parameter int ALMOST_EMPTY_NUM = AE_NUM
) (
    input  logic                      wr_clk,
    input  logic                      wr_rst,
    input  logic                      rd_clk,
    input  logic                      rd_rst,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    input  logic                      wr_en,
    output logic                      wr_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    output logic                      almost_full,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    input  logic                      rd_en,
    output logic                      rd_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    output logic                      almost_empty
);

    localparam int WPW = WR_DEPTH_WIDTH + 1;
    localparam int RPW = RD_DEPTH_WIDTH + 1;
    localparam int SH  = WR_DEPTH_WIDTH - RD_DEPTH_WIDTH;
    localparam int NB  = 1 << SH;
    localparam int RD  = 1 << RD_DEPTH_WIDTH;

    logic                     rst;
    logic                     wr_ok;
    logic                     rd_ok;
    logic [WPW-1:0]           wr_ptr;
    logic [WPW-1:0]           wr_ptr_nxt;
    logic [WPW-1:0]           wr_gray;
    logic [WPW-1:0]           wr_gray_s;
    logic [WPW-1:0]           wr_ptr_r;
    logic [WPW-1:0]           wr_level_nxt;
    logic [WPW-1:0]           rd_gray;
    logic [WPW-1:0]           rd_gray_s;
    logic [WPW-1:0]           rd_ptr_w;
    logic [RPW-1:0]           rd_ptr;
    logic [RPW-1:0]           rd_ptr_nxt;
    logic [RPW-1:0]           rd_level_nxt;
    logic [WR_DATA_WIDTH-1:0] mem [NB][RD];

    // Either domain's reset empties the whole FIFO.
    assign rst = wr_rst | rd_rst;

    // Write domain
    assign wr_ok        = wr_en & ~wr_full;
    assign wr_ptr_nxt   = wr_ptr + WPW'(wr_ok);
    assign rd_ptr_w     = gray2bin(rd_gray_s);
    assign wr_level_nxt = wr_ptr_nxt - (rd_ptr_w << SH);

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            wr_gray        <= '0;
            wr_water_level <= '0;
            wr_full        <= 1'b0;
            almost_full    <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            wr_gray        <= bin2gray(wr_ptr_nxt);
            wr_water_level <= wr_level_nxt;
            wr_full        <= wr_level_nxt == WPW'(1 << WR_DEPTH_WIDTH);
            almost_full    <= wr_level_nxt >= WPW'(ALMOST_FULL_NUM);
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_ok)
            mem[wr_ptr[SH-1:0]][wr_ptr[WR_DEPTH_WIDTH-1:SH]] <= wr_data;
    end

    fifo_in_sync2 #(.W(WPW)) u_sync_wr (
        .clk (rd_clk),
        .rst (rst),
        .d   (wr_gray),
        .q   (wr_gray_s)
    );

    fifo_in_sync2 #(.W(WPW)) u_sync_rd (
        .clk (wr_clk),
        .rst (rst),
        .d   (rd_gray),
        .q   (rd_gray_s)
    );

    // Read domain: only complete groups of NB writes are visible.
    assign rd_ok        = rd_en & ~rd_empty;
    assign rd_ptr_nxt   = rd_ptr + RPW'(rd_ok);
    assign wr_ptr_r     = gray2bin(wr_gray_s);
    assign rd_level_nxt = RPW'(wr_ptr_r >> SH) - rd_ptr_nxt;

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            rd_ptr         <= '0;
            rd_gray        <= '0;
            rd_water_level <= '0;
            rd_empty       <= 1'b1;
            almost_empty   <= 1'b1;
            rd_data        <= '0;
        end else begin
            rd_ptr         <= rd_ptr_nxt;
            rd_gray        <= bin2gray(WPW'(rd_ptr_nxt));
            rd_water_level <= rd_level_nxt;
            rd_empty       <= rd_level_nxt == '0;
            almost_empty   <= rd_level_nxt <= RPW'(ALMOST_EMPTY_NUM);
            if (rd_ok) begin
                for (int b = 0; b < NB; b++)
                    rd_data[b*WR_DATA_WIDTH +: WR_DATA_WIDTH] <=
                        mem[b][rd_ptr[RD_DEPTH_WIDTH-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_fifo_in.sv
// Randomized scoreboard bench for fifo_in: packs accepted writes into
// expected 256-bit words and checks every accepted read against them.
module tb_fifo_in;

    logic         clk = 1'b0;
    logic         tb_rst = 1'b1;
    logic [31:0]  wr_data = '0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic         wr_full;
    logic [10:0]  wr_water_level;
    logic         almost_full;
    logic [255:0] rd_data;
    logic         rd_empty;
    logic [7:0]   rd_water_level;
    logic         almost_empty;

    int n_cmp = 0;
    int n_bad = 0;
    int n_rd  = 0;

    logic [31:0]  wq[$];
    logic [255:0] exp_q[$];

    fifo_in dut (
        .wr_clk         (clk),
        .wr_rst         (tb_rst),
        .rd_clk         (clk),
        .rd_rst         (tb_rst),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .wr_water_level (wr_water_level),
        .almost_full    (almost_full),
        .rd_data        (rd_data),
        .rd_en          (rd_en),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .almost_empty   (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tb_rst = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        wq.delete();
        exp_q.delete();
        repeat (2) step();
        tb_rst = 1'b0;
        step();
    endtask

    task automatic drain();
        repeat (200) begin
            rd_en = !rd_empty;
            step();
        end
        rd_en = 1'b0;
        repeat (6) step();
        chk("drain_left", exp_q.size(), 0);
        chk("drain_empty", rd_empty, 1'b1);
    endtask

    // Write monitor: model of accepted writes, grouped by eight.
    initial begin
        logic [255:0] w;
        forever begin
            @(posedge clk);
            if (!tb_rst && wr_en && !wr_full) begin
                n_cmp++;
                if (wq.size() + 8 * exp_q.size() >= 1024) begin
                    n_bad++;
                    $display("FAIL overflow: write accepted at model level %0d",
                             wq.size() + 8 * exp_q.size());
                end
                wq.push_back(wr_data);
                if (wq.size() == 8) begin
                    for (int k = 0; k < 8; k++)
                        w[k*32 +: 32] = wq[k];
                    exp_q.push_back(w);
                    wq.delete();
                end
            end
        end
    end

    // Read monitor: data is checked half a cycle after acceptance.
    initial begin
        bit fire;
        forever begin
            @(posedge clk);
            fire = !tb_rst && rd_en && !rd_empty;
            @(negedge clk);
            if (fire && !tb_rst) begin
                n_rd++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL underflow: read accepted, actual %0h required none",
                             rd_data);
                end else begin
                    chk("rd_data", rd_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           cnt;
        int           lat;
        int           rd0;
        logic [31:0]  first;
        logic [255:0] w;

        // Reset values
        repeat (2) step();
        chk("rst_wr_full", wr_full, 1'b0);
        chk("rst_almost_full", almost_full, 1'b0);
        chk("rst_wr_level", wr_water_level, 0);
        chk("rst_rd_empty", rd_empty, 1'b1);
        chk("rst_almost_empty", almost_empty, 1'b1);
        chk("rst_rd_level", rd_water_level, 0);
        chk("rst_rd_data", rd_data, 0);
        tb_rst = 1'b0;
        step();

        // Partial group invisibility and almost_empty threshold
        for (int i = 0; i < 7; i++) begin
            wr_data = $urandom;
            wr_en   = 1'b1;
            step();
        end
        wr_en = 1'b0;
        repeat (6) step();
        chk("partial_empty", rd_empty, 1'b1);
        chk("partial_level", rd_water_level, 0);
        wr_data = $urandom;
        wr_en   = 1'b1;
        step();
        wr_en = 1'b0;
        lat   = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (!rd_empty) begin
                lat = i;
                break;
            end
        end
        chk("empty_deassert_2to4", (lat >= 2 && lat <= 4), 1'b1);
        chk("one_word_level", rd_water_level, 1);
        chk("one_word_ae", almost_empty, 1'b1);
        for (int i = 0; i < 24; i++) begin
            wr_data = $urandom;
            wr_en   = 1'b1;
            step();
        end
        wr_en = 1'b0;
        repeat (6) step();
        chk("lvl4", rd_water_level, 4);
        chk("lvl4_ae", almost_empty, 1'b1);
        for (int i = 0; i < 8; i++) begin
            wr_data = $urandom;
            wr_en   = 1'b1;
            step();
        end
        wr_en = 1'b0;
        repeat (6) step();
        chk("lvl5", rd_water_level, 5);
        chk("lvl5_ae", almost_empty, 1'b0);
        chk("wr_lvl40", wr_water_level, 40);
        drain();
        chk("drained_wr_lvl", wr_water_level, 0);

        // Fill from empty with a down-counting pattern
        do_reset();
        cnt = 0;
        for (int i = 0; i <= 1024; i++) begin
            wr_data = 32'hFFFF_FFFF - 32'(i);
            wr_en   = 1'b1;
            step();
            if (cnt < 1024)
                cnt++;
            chk("fill_level", wr_water_level, cnt);
            chk("fill_af", almost_full, cnt >= 1020);
            chk("fill_full", wr_full, cnt == 1024);
        end
        wr_en = 1'b0;
        repeat (6) step();
        chk("fill_rd_level", rd_water_level, 128);
        chk("fill_ae", almost_empty, 1'b0);

        // 129 read attempts
        rd0 = n_rd;
        for (int k = 0; k < 8; k++)
            w[k*32 +: 32] = 32'hFFFF_FFFF - 32'(k);
        rd_en = 1'b1;
        step();
        chk("first_rd_word", rd_data, w);
        for (int i = 1; i < 129; i++)
            step();
        rd_en = 1'b0;
        step();
        for (int k = 0; k < 8; k++)
            w[k*32 +: 32] = 32'hFFFF_FFFF - 32'(1016 + k);
        chk("last_rd_hold", rd_data, w);
        chk("after_drain_empty", rd_empty, 1'b1);
        chk("reads_accepted", n_rd - rd0, 128);
        repeat (6) step();
        chk("post_read_wr_level", wr_water_level, 0);
        chk("post_read_full", wr_full, 1'b0);
        chk("post_read_af", almost_full, 1'b0);

        // Simultaneous traffic
        do_reset();
        for (int c = 0; c < 5000; c++) begin
            wr_data = $urandom;
            if (c < 2500) begin
                wr_en = 1'b1;
                rd_en = !rd_empty;
            end else begin
                wr_en = $urandom_range(0, 3) != 0;
                rd_en = !rd_empty && ($urandom_range(0, 31) == 0);
            end
            step();
        end
        wr_en = 1'b0;
        drain();

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 500; i++) begin
            wr_data = $urandom;
            wr_en   = 1'b1;
            step();
        end
        wr_en = 1'b0;
        repeat (6) step();
        chk("lvl500", wr_water_level, 500);
        tb_rst = 1'b1;
        #1;
        chk("midrst_wr_level", wr_water_level, 0);
        chk("midrst_rd_empty", rd_empty, 1'b1);
        chk("midrst_wr_full", wr_full, 1'b0);
        chk("midrst_rd_data", rd_data, 0);
        wq.delete();
        exp_q.delete();
        step();
        tb_rst = 1'b0;
        step();
        first = $urandom;
        for (int i = 0; i < 8; i++) begin
            wr_data = (i == 0) ? first : $urandom;
            wr_en   = 1'b1;
            step();
        end
        wr_en = 1'b0;
        lat   = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (!rd_empty) begin
                lat = i;
                break;
            end
        end
        chk("post_rst_visible", lat != 0, 1'b1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        w = rd_data;
        chk("post_rst_first", w[31:0], first);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
